fp16_div_seq: RTL and testbench



---
 rtl/fp16_div_seq.sv | 161 ++++++++++++++++
 tb/tb_fp16_div_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fp16_div_seq.sv
// Iterative FP16 divider: exponent subtract with bias re-add, radix-2 restoring
// mantissa division (one quotient bit per cycle), truncating rounding.
module fp16_div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] q,
   output logic        ovf,
   output logic        unf,
   output logic        dz,
   output logic [1:0]  state_dbg
);

   // Handshakes: operands transfer on an edge with in_valid && in_ready; the
   // result transfers on an edge with out_valid && out_ready. out_valid, q and
   // the flags stay stable until that transfer; in_ready is high only in IDLE.
   typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, NORM = 2'd2, DONE = 2'd3} state_t;

   state_t      state;
   logic        sign;
   logic [4:0]  ea, eb;
   logic [11:0] rem, mb, qm;
   logic [3:0]  cnt;

   logic [4:0]  a_exp, b_exp;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
   logic        spec, spec_dz;
   logic [15:0] spec_q;
   logic [11:0] rem_diff;
   logic        rem_ge;
   logic signed [6:0] e_raw, e_norm;
   logic [9:0]  frac_norm;

   assign state_dbg = state;

   // Subnormals (exp == 0) are treated as zero.
   always_comb begin
      a_exp  = a[14:10];
      b_exp  = b[14:10];
      sgn    = a[15] ^ b[15];
      a_zero = (a_exp == 5'd0);
      b_zero = (b_exp == 5'd0);
      a_inf  = (a_exp == 5'd31) && (a[9:0] == 10'd0);
      b_inf  = (b_exp == 5'd31) && (b[9:0] == 10'd0);
      a_nan  = (a_exp == 5'd31) && (a[9:0] != 10'd0);
      b_nan  = (b_exp == 5'd31) && (b[9:0] != 10'd0);
      spec    = 1'b1;
      spec_q  = 16'h0000;
      spec_dz = 1'b0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
         spec_q = 16'h7E00;
      else if (a_inf)
         spec_q = {sgn, 15'h7C00};
      else if (b_inf)
         spec_q = {sgn, 15'h0000};
      else if (a_zero)
         spec_q = {sgn, 15'h0000};
      else if (b_zero) begin
         spec_q  = {sgn, 15'h7C00};
         spec_dz = 1'b1;
      end else
         spec = 1'b0;
   end

   always_comb begin
      rem_diff = rem - mb;
      rem_ge   = (rem >= mb);
      e_raw    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 7'sd15;
      if (qm[11]) begin
         e_norm    = e_raw;
         frac_norm = qm[10:1];
      end else begin
         e_norm    = e_raw - 7'sd1;
         frac_norm = qm[9:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         q         <= 16'h0000;
         ovf       <= 1'b0;
         unf       <= 1'b0;
         dz        <= 1'b0;
         cnt       <= 4'd0;
         sign      <= 1'b0;
         ea        <= 5'd0;
         eb        <= 5'd0;
         rem       <= 12'd0;
         mb        <= 12'd0;
         qm        <= 12'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign     <= sgn;
                  ea       <= a_exp;
                  eb       <= b_exp;
                  rem      <= {2'b01, a[9:0]};
                  mb       <= {2'b01, b[9:0]};
                  qm       <= 12'd0;
                  cnt      <= 4'd0;
                  in_ready <= 1'b0;
                  if (spec) begin
                     q         <= spec_q;
                     dz        <= spec_dz;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else
                     state <= DIV;
               end
            end
            DIV: begin
               if (rem_ge) begin
                  qm  <= {qm[10:0], 1'b1};
                  rem <= {rem_diff[10:0], 1'b0};
               end else begin
                  qm  <= {qm[10:0], 1'b0};
                  rem <= {rem[10:0], 1'b0};
               end
               if (cnt == 4'd11) begin
                  cnt   <= 4'd0;
                  state <= NORM;
               end else
                  cnt <= cnt + 4'd1;
            end
            NORM: begin
               if (e_norm >= 7'sd31) begin
                  q   <= {sign, 15'h7C00};
                  ovf <= 1'b1;
               end else if (e_norm <= 7'sd0) begin
                  q   <= {sign, 15'h0000};
                  unf <= 1'b1;
               end else
                  q <= {sign, e_norm[4:0], frac_norm};
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  ovf       <= 1'b0;
                  unf       <= 1'b0;
                  dz        <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_div_seq.sv
// Bench for fp16_div_seq: vector table, random normal operands against an
// integer-division model, backpressure and mid-division reset sequences.
module tb_fp16_div_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = 16'h0000;
   logic [15:0] b = 16'h0000;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] q;
   logic        ovf, unf, dz;
   logic [1:0]  state_dbg;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   logic [18:0] exp_q[$];

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [18:0] res;   // {q, ovf, unf, dz}
      int          lat;   // edges from handshake to first out_valid sample
   } vec_t;
   vec_t tbl[16];

   fp16_div_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .q(q), .ovf(ovf), .unf(unf), .dz(dz), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      chk_cnt++;
      if (act === want) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string nm);
      int w = 0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) check({nm, " ready timeout"}, {31'd0, in_ready}, 32'd1);
   endtask

   // Drive one operand pair, measure latency, compare against the scoreboard.
   task automatic do_op(input logic [15:0] aa, input logic [15:0] bb,
                        input logic [18:0] expv, input int exp_lat, input string nm);
      int lat;
      logic [18:0] want;
      exp_q.push_back(expv);
      wait_ready(nm);
      a = aa;
      b = bb;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check({nm, " latency"}, lat, exp_lat);
      want = exp_q.pop_front();
      check({nm, " result"}, {13'd0, q, ovf, unf, dz}, {13'd0, want});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({nm, " in_ready after"}, {31'd0, in_ready}, 32'd1);
   endtask

   function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y);
      int ma, mb, mant, e;
      logic s;
      s  = x[15] ^ y[15];
      ma = 1024 + int'(x[9:0]);
      mb = 1024 + int'(y[9:0]);
      if (ma >= mb) begin
         mant = (ma * 1024) / mb;
         e    = int'(x[14:10]) - int'(y[14:10]) + 15;
      end else begin
         mant = (ma * 2048) / mb;
         e    = int'(x[14:10]) - int'(y[14:10]) + 14;
      end
      if (e >= 31) return {s, 15'h7C00, 3'b100};
      if (e <= 0)  return {s, 15'h0000, 3'b010};
      return {s, e[4:0], mant[9:0], 3'b000};
   endfunction

   initial begin
      logic [15:0] ra, rb;
      logic [18:0] want;
      int lat;

      tbl[0]  = '{16'h4000, 16'h3C00, {16'h4000, 3'b000}, 13};
      tbl[1]  = '{16'h3C00, 16'h4200, {16'h3555, 3'b000}, 13};
      tbl[2]  = '{16'h4600, 16'hBE00, {16'hC400, 3'b000}, 13};
      tbl[3]  = '{16'h7BFF, 16'h0400, {16'h7C00, 3'b100}, 13};
      tbl[4]  = '{16'h0400, 16'h7BFF, {16'h0000, 3'b010}, 13};
      tbl[5]  = '{16'h3C00, 16'h0000, {16'h7C00, 3'b001}, 0};
      tbl[6]  = '{16'h0000, 16'h0000, {16'h7E00, 3'b000}, 0};
      tbl[7]  = '{16'h7C01, 16'h3C00, {16'h7E00, 3'b000}, 0};
      tbl[8]  = '{16'hFC00, 16'hFC00, {16'h7E00, 3'b000}, 0};
      tbl[9]  = '{16'hFC00, 16'h4000, {16'hFC00, 3'b000}, 0};
      tbl[10] = '{16'hC000, 16'h7C00, {16'h8000, 3'b000}, 0};
      tbl[11] = '{16'h0000, 16'hC000, {16'h8000, 3'b000}, 0};
      tbl[12] = '{16'h0001, 16'h3C00, {16'h0000, 3'b000}, 0};
      tbl[13] = '{16'hBC00, 16'h0001, {16'hFC00, 3'b001}, 0};
      tbl[14] = '{16'h3E00, 16'h4000, {16'h3A00, 3'b000}, 13};
      tbl[15] = '{16'h3C00, 16'h3C00, {16'h3C00, 3'b000}, 13};

      repeat (3) tick();
      rst = 1'b0;
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset q", {16'd0, q}, 32'h0000);
      check("reset flags", {29'd0, ovf, unf, dz}, 32'd0);
      check("reset state", {30'd0, state_dbg}, 32'd0);

      for (int i = 0; i < 16; i++)
         do_op(tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat, $sformatf("vec%0d", i));

      for (int i = 0; i < 8; i++) begin
         ra = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
         rb = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
         do_op(ra, rb, model(ra, rb), 13, $sformatf("rand%0d %h/%h", i, ra, rb));
      end

      // Backpressure: result and flags held, busy in_valid ignored.
      exp_q.push_back({16'h7C00, 3'b100});
      wait_ready("bp");
      a = 16'h7BFF;
      b = 16'h0400;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("bp latency", lat, 13);
      want = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         check("bp held result", {13'd0, q, ovf, unf, dz}, {13'd0, want});
         check("bp in_ready", {31'd0, in_ready}, 32'd0);
         check("bp out_valid", {31'd0, out_valid}, 32'd1);
         if (i == 1) begin
            a = 16'h3C00;
            b = 16'h4200;
            in_valid = 1'b1;
         end else
            in_valid = 1'b0;
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp in_ready after", {31'd0, in_ready}, 32'd1);
      check("bp out_valid after", {31'd0, out_valid}, 32'd0);
      check("bp flags cleared", {29'd0, ovf, unf, dz}, 32'd0);
      tick();
      check("bp no extra result", {31'd0, out_valid}, 32'd0);

      // Reset during DIV discards the in-flight division.
      wait_ready("rst");
      a = 16'h4000;
      b = 16'h3C00;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
      check("mid reset in_ready", {31'd0, in_ready}, 32'd1);
      check("mid reset q", {16'd0, q}, 32'h0000);
      check("mid reset state", {30'd0, state_dbg}, 32'd0);
      repeat (16) tick();
      check("mid reset no result", {31'd0, out_valid}, 32'd0);
      do_op(16'h4000, 16'h3C00, {16'h4000, 3'b000}, 13, "after reset");

      check("scoreboard empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
